// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared constants and state type for the source-mux scheduler.
// Holds mux geometry, the idle select code and the two-state FSM encoding.
package mux_sched_pkg;

    localparam int N_SRC = 10;
    localparam int SEL_W = 7;
    localparam int DW    = 16;
    localparam int IDX_W = 4;

    // Mux select code that routes the zero input.
    localparam logic [SEL_W-1:0] SEL_IDLE = 7'd10;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

endpackage

// File: rtl/mux_src_sched_rr_pick.sv
// rr_pick: combinational round-robin finder over N_SRC requesters.
// Ports: req (requests), ptr (last winner) -> found, idx (first set req after ptr, wrapping).
module rr_pick #(
    parameter int N_SRC = 10,
    parameter int IW    = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    int          w_j;
    logic [IW-1:0] w_jj;

    // Walk offsets from far to near so the nearest hit after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = 0;
        w_jj  = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_j = int'(ptr) + k;
            if (w_j >= N_SRC) begin
                w_j = w_j - N_SRC;
            end
            w_jj = IW'(w_j);
            if (req[w_jj]) begin
                found = 1'b1;
                idx   = w_jj;
            end
        end
    end

endmodule

// File: rtl/mux_src_sched.sv
// mux_src_sched: round-robin owner of the shared source mux; streams the granted
// input out in bursts. Ports: clk, rst_n, enable, req -> sel, gnt, busy;
// mux_data -> out_data/out_valid with out_ready backpressure.
module mux_src_sched #(
    parameter int N_SRC     = mux_sched_pkg::N_SRC,
    parameter int SEL_W     = mux_sched_pkg::SEL_W,
    parameter int DW        = mux_sched_pkg::DW,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_SRC-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] gnt,
    input  logic [DW-1:0]    mux_data,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    import mux_sched_pkg::*;

    localparam int PW = $clog2(N_SRC);

    state_e           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_w, w_w_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [N_SRC-1:0] r_gnt, w_gnt_nxt;
    logic [DW-1:0]    r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;

    logic             w_found;
    logic [PW-1:0]    w_idx;
    logic             w_load_opp;

    rr_pick #(
        .N_SRC (N_SRC),
        .IW    (PW)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // A new beat may enter the output register when it is empty or draining.
    assign w_load_opp = !r_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= PW'(N_SRC - 1);
            r_w     <= '0;
            r_cnt   <= '0;
            r_sel   <= SEL_W'(SEL_IDLE);
            r_gnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_w     <= w_w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_w_nxt     = r_w;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        unique case (r_state)
            IDLE: begin
                // A beat left over from the last burst can still drain here.
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                end
                if (enable && w_found) begin
                    w_w_nxt          = w_idx;
                    w_ptr_nxt        = w_idx;
                    w_cnt_nxt        = '0;
                    w_sel_nxt        = SEL_W'(w_idx);
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_idx] = 1'b1;
                    w_state_nxt      = XFER;
                end
            end
            XFER: begin
                if (w_load_opp) begin
                    if (req[r_w] && (r_cnt < 4'(MAX_BURST))) begin
                        w_data_nxt  = mux_data;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else begin
                        // No load: register is empty or its beat is taken now.
                        w_valid_nxt = 1'b0;
                        w_sel_nxt   = SEL_W'(SEL_IDLE);
                        w_gnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = (r_state == XFER);

endmodule

// File: doc/mux_src_sched.md
# mux_src_sched

Round-robin scheduler that shares the 10-input, 16-bit source mux between its requesters. It arbitrates among per-source requests, drives the mux select and a one-hot grant, and streams the selected mux output through a registered valid/ready port in bounded bursts. The block sits directly upstream of the mux select and downstream of the mux data output.

## Interface
Parameters:
- N_SRC, 10: number of requesters, equal to the number of mux data inputs.
- SEL_W, 7: mux select width.
- DW, 16: data width.
- MAX_BURST, 4: maximum number of beats per grant (1..15).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- enable  input  1  when low, no new grants are issued.
- req  input  N_SRC  per-source request, level-sensitive.
- sel  output  SEL_W  mux select; holds the granted index, or SEL_IDLE (10, the mux zero code) when idle.
- gnt  output  N_SRC  one-hot grant; all zero when idle.
- mux_data  input  DW  the mux output for the current sel.
- out_data  output  DW  registered beat data.
- out_valid  output  1  out_data holds an unaccepted beat.
- out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
- busy  output  1  high while in the XFER state.

## Operation
- State machine has two states: IDLE and XFER. Registers: ptr (last winner), w (current winner), beat_cnt (4 bits).
- **IDLE:**
  - sel = SEL_IDLE and gnt = 0.
  - If enable is high and req is non-zero, choose w as the first set req bit searching ptr+1, ptr+2, … with wrap 9→0, ending at ptr itself.
  - Then register sel←w, gnt←onehot(w), ptr←w and beat_cnt←0, and go to XFER.
  - Otherwise stay in IDLE.
- **XFER:**
  - Define a load opportunity as (!out_valid || out_ready).
  - On a load opportunity with req[w]=1 and beat_cnt<MAX_BURST: out_data←mux_data, out_valid←1, beat_cnt←beat_cnt+1.
  - On a load opportunity with req[w]=0, or with beat_cnt==MAX_BURST: no load. Set sel←SEL_IDLE and gnt←0, and go to IDLE.
  - If out_ready is high in the same cycle, out_valid←0.
  - Without a load opportunity (stalled): hold all state, sel, gnt and out_data.
- out_valid clears on acceptance whenever no new beat loads in that cycle, in either state.
- enable going low during XFER does not cut the burst short; the burst finishes and the block stays in IDLE afterwards.
- req[w] dropping while stalled has no effect until the next load opportunity.
- A requester re-requesting immediately after its burst competes normally. Because ptr has advanced, other requesters win first.
- Requests are never lost. Every continuously asserted req is granted within N_SRC arbitration rounds.

## Timing
- Reset (asynchronous, immediate) sets: state=IDLE, ptr=N_SRC-1 (so the first search starts at 0), w=0, beat_cnt=0, sel=SEL_IDLE, gnt=0, out_data=0, out_valid=0, busy=0.
- Latency: if req is seen in IDLE at edge t, sel and gnt are valid after t and the first beat is in out_valid/out_data after edge t+1.
- mux_data is treated as a combinational function of sel. It is sampled only in XFER, at least one cycle after sel changes.
- Between bursts there is exactly one IDLE cycle with sel=SEL_IDLE.
- With out_ready held high, a full burst is MAX_BURST consecutive beats, and the burst period is MAX_BURST+2 cycles.
- If reset is asserted mid-burst, the pending beat is discarded. No handshake completes while rst_n is low.

## Structure
- Shared package mux_sched_pkg holds:
  - N_SRC, SEL_W, DW;
  - SEL_IDLE = 7'd10;
  - the state typedef {IDLE, XFER}.
- Sub-module rr_pick: combinational round-robin finder.
  - Inputs: req, ptr.
  - Outputs: found, idx.
  - Instantiated once, in the IDLE arbitration path.

## Test plan
- Reset mid-burst (rst_n low while out_valid=1) -> all outputs immediately at reset values; after release, first grant goes to the lowest set req from index 0.
- Single requester: req[3]=1 held, out_ready=1, mux_data=16'h0300+beat -> sel=3, exactly 4 beats, one IDLE cycle with sel=10, then a new 4-beat burst on 3.
- Round-robin: req=10'b10_0000_0101 held -> grant order 0, 2, 9, 0, 2, … including the wrap from 9 to 0; each burst is 4 beats.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_valid and out_data held constant, beat_cnt frozen, total beats still 4.
- Early drop: req[5] deasserted after the 2nd beat is loaded -> exactly 2 beats are delivered, then IDLE with sel=10 and gnt=0.
- Enable low mid-burst -> current burst completes with 4 beats, then sel=10 and busy=0 with req still high; enable high again -> arbitration resumes from ptr+1.
